// File: rtl/sca_ctl_pkg.sv
// Shared code constants and helpers for the SCA control-bus mode decoder.
package sca_ctl_pkg;

  localparam int MODE_IDLE             = 0;
  localparam int MODE_TX_SYNC          = 1;
  localparam int MODE_GBT_LOOPBACK     = 2;
  localparam int MODE_LED_SYNC         = 3;
  localparam int DEFAULT_STABLE_CYCLES = 4;
  localparam int MAX_MODES             = 256;

  // Returns a one-hot vector with bit 'code' set; callers cast it down to their own mode count.
  function automatic logic [MAX_MODES-1:0] onehot(input int code, input int num_modes);
    logic [MAX_MODES-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_MODES; i++) begin
      if (i == code && i < num_modes) v[i[7:0]] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/sca_ctl_filter.sv
// Two-flop synchroniser plus stable-run qualifier for the raw SCA control lines.
module sca_ctl_filter
  import sca_ctl_pkg::*;
#(
  parameter int CTL_WIDTH     = 3,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [CTL_WIDTH-1:0] sca_ctl,
  output logic [CTL_WIDTH-1:0] candidate,
  output logic                 accept
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [CTL_WIDTH-1:0] sync_q1;
  logic [CTL_WIDTH-1:0] ctl_s;
  logic [CTL_WIDTH-1:0] cand_q;
  logic [7:0]           cnt_q;
  logic [7:0]           cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      ctl_s   <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync_q1 <= sca_ctl;
      ctl_s   <= sync_q1;
      cand_q  <= ctl_s;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every branch assigns cnt_d, so no latch is inferred.
  always_comb begin
    if (ctl_s != cand_q)          cnt_d = 8'd1;
    else if (cnt_q == STABLE_MAX) cnt_d = cnt_q;
    else                          cnt_d = cnt_q + 8'd1;
  end

  // Strobe on the edge where the run reaches its threshold, so the top can commit on that same edge.
  assign accept    = (cnt_d == STABLE_MAX) && ((cnt_q != STABLE_MAX) || (ctl_s != cand_q));
  assign candidate = ctl_s;

endmodule

// File: rtl/sca_mode_decoder.sv
// Qualifies the SCA control bus and decodes it into registered mode levels, pulses and a change count.
module sca_mode_decoder
  import sca_ctl_pkg::*;
#(
  parameter int  CTL_WIDTH     = 3,
  parameter int  STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int  MAX_CODE      = MODE_LED_SYNC,
  parameter int  CNT_WIDTH     = 8,
  parameter int  TX_SYNC_CODE  = MODE_TX_SYNC,
  parameter int  LOOPBACK_CODE = MODE_GBT_LOOPBACK,
  parameter int  LED_SYNC_CODE = MODE_LED_SYNC,
  localparam int NUM_MODES     = 2**CTL_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n_i,
  input  logic [CTL_WIDTH-1:0] sca_ctl_i,
  output logic [NUM_MODES-1:0] mode_onehot_o,
  output logic [CTL_WIDTH-1:0] active_code_o,
  output logic                 tx_sync_mode,
  output logic                 gbt_loopback_mode,
  output logic                 led_sync_mode,
  output logic                 mode_change_o,
  output logic                 illegal_code_o,
  output logic [CNT_WIDTH-1:0] change_cnt_o
);

  localparam logic [CTL_WIDTH-1:0] IDLE_C = CTL_WIDTH'(MODE_IDLE);
  localparam logic [CTL_WIDTH-1:0] MAX_C  = CTL_WIDTH'(MAX_CODE);
  localparam logic [CTL_WIDTH-1:0] TX_C   = CTL_WIDTH'(TX_SYNC_CODE);
  localparam logic [CTL_WIDTH-1:0] LB_C   = CTL_WIDTH'(LOOPBACK_CODE);
  localparam logic [CTL_WIDTH-1:0] LED_C  = CTL_WIDTH'(LED_SYNC_CODE);

  logic [1:0]           rst_sync_q;
  logic                 reset_n;
  logic [CTL_WIDTH-1:0] candidate;
  logic                 accept;
  logic [CTL_WIDTH-1:0] active_d;
  logic                 change_d;
  logic                 illegal_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [NUM_MODES-1:0] onehot_d;

  // Asserts with reset_n_i, releases two clocks after it.
  always_ff @(posedge clock or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_q <= '0;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign reset_n = rst_sync_q[1];

  sca_ctl_filter #(
    .CTL_WIDTH    (CTL_WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clock    (clock),
    .reset_n  (reset_n),
    .sca_ctl  (sca_ctl_i),
    .candidate(candidate),
    .accept   (accept)
  );

  // Reserved codes fall back to idle; a change pulse only if that actually moves the active code.
  always_comb begin
    active_d  = active_code_o;
    change_d  = 1'b0;
    illegal_d = 1'b0;
    if (accept && (candidate != active_code_o)) begin
      if (candidate > MAX_C) begin
        active_d  = IDLE_C;
        illegal_d = 1'b1;
        change_d  = (active_code_o != IDLE_C);
      end else begin
        active_d  = candidate;
        change_d  = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = change_cnt_o;
    if (change_d && (change_cnt_o != '1)) cnt_d = change_cnt_o + 1'b1;
  end

  assign onehot_d = NUM_MODES'(onehot(int'(active_d), NUM_MODES));

  // NOTE: reset is asynchronous assert so outputs drop to idle without waiting for a clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_code_o     <= IDLE_C;
      mode_onehot_o     <= NUM_MODES'(1);
      tx_sync_mode      <= 1'b0;
      gbt_loopback_mode <= 1'b0;
      led_sync_mode     <= 1'b0;
      mode_change_o     <= 1'b0;
      illegal_code_o    <= 1'b0;
      change_cnt_o      <= '0;
    end else begin
      active_code_o     <= active_d;
      mode_onehot_o     <= onehot_d;
      tx_sync_mode      <= (active_d == TX_C);
      gbt_loopback_mode <= (active_d == LB_C);
      led_sync_mode     <= (active_d == LED_C) || (active_d == LB_C);
      mode_change_o     <= change_d;
      illegal_code_o    <= illegal_d;
      change_cnt_o      <= cnt_d;
    end
  end

endmodule
